// File: rtl/toggle_cover_pkg.sv
// Shared definitions for the toggle coverage detector: FSM states and the default
// number of monitored bits.
package toggle_cover_pkg;

    localparam int COVER_TOTAL = 29;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cover_state_e;

endpackage

// File: rtl/toggle_cover_detect_popcount.sv
// Counts the set bits of a vector, for the covered-bit counter increment.
// Purely combinational; no flow control.
module toggle_popcount #(
    parameter int WIDTH = 29,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_o = cnt_o + CNT_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/toggle_cover_detect.sv
// Per-bit toggle coverage: pulses valid once per bit on its first full rise+fall
// and counts the covered bits. The pulse is registered one cycle after the sample; there is no backpressure.
module toggle_cover_detect
    import toggle_cover_pkg::*;
#(
    parameter int WIDTH = COVER_TOTAL,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             gbl_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] valid,
    output logic [CNT_W-1:0] covered_cnt,
    output logic             all_covered
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

    cover_state_e     state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] seen_rise_q, seen_rise_d;
    logic [WIDTH-1:0] seen_fall_q, seen_fall_d;
    logic [WIDTH-1:0] valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] rise, fall;
    logic [WIDTH-1:0] seen_rise_nxt, seen_fall_nxt;
    logic [WIDTH-1:0] complete_q, complete_nxt, newly;
    logic [CNT_W-1:0] newly_cnt, cnt_sum;

    assign rise          = ~prev_q & sig;
    assign fall          = prev_q & ~sig;
    assign seen_rise_nxt = seen_rise_q | rise;
    assign seen_fall_nxt = seen_fall_q | fall;
    assign complete_q    = seen_rise_q & seen_fall_q;
    assign complete_nxt  = seen_rise_nxt & seen_fall_nxt;
    assign newly         = complete_nxt & ~complete_q;

    toggle_popcount #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_popcount (
        .vec_i (newly),
        .cnt_o (newly_cnt)
    );

    // Cannot exceed WIDTH: newly only covers bits not already counted.
    assign cnt_sum = cnt_q + newly_cnt;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        seen_rise_d = seen_rise_q;
        seen_fall_d = seen_fall_q;
        valid_d     = '0;
        cnt_d       = cnt_q;

        if (clr) begin
            // The sample presented with clr is dropped; ARM recaptures prev on the next en.
            seen_rise_d = '0;
            seen_fall_d = '0;
            cnt_d       = '0;
            state_d     = ARM;
        end else begin
            unique case (state_q)
                ARM: begin
                    if (en) begin
                        prev_d  = sig;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        prev_d      = sig;
                        seen_rise_d = seen_rise_nxt;
                        seen_fall_d = seen_fall_nxt;
                        valid_d     = newly;
                        cnt_d       = cnt_sum;
                        if (cnt_sum == FULL_CNT) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = ARM;
                end
            endcase
        end
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            state_q     <= ARM;
            prev_q      <= '0;
            seen_rise_q <= '0;
            seen_fall_q <= '0;
            valid_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            seen_rise_q <= seen_rise_d;
            seen_fall_q <= seen_fall_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign valid       = valid_q;
    assign covered_cnt = cnt_q;
    assign all_covered = (cnt_q == FULL_CNT);

endmodule

// File: doc/toggle_cover_detect.md
TOGGLE_COVER_DETECT -- requirements
Module: toggle_cover_detect

Interface
REQ-001 SHALL have parameter WIDTH, default 29, number of monitored signal bits (1..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), width of the covered-bit counter.
REQ-003 SHALL have port gbl_clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1; reset is synchronous, active-low; clock is gbl_clk.
REQ-005 SHALL have port en, input, 1, sample-enable for the monitored vector.
REQ-006 SHALL have port clr, input, 1, synchronous coverage clear.
REQ-007 SHALL have port sig, input, WIDTH, monitored signal vector.
REQ-008 SHALL have port valid, output, WIDTH, one-cycle pulse per bit on first full toggle; feeds the toggle cover reporter's valid input.
REQ-009 SHALL have port covered_cnt, output, CNT_W, number of bits fully toggled since last clear.
REQ-010 SHALL have port all_covered, output, 1, high while covered_cnt == WIDTH.

Function
REQ-011 SHALL implement states ARM, RUN and DONE.
REQ-012 ARM: first cycle with en=1 SHALL capture sig into prev_q, perform no detection, and go to RUN.
REQ-013 RUN: each cycle with en=1 SHALL compute rise = ~prev_q & sig and fall = prev_q & ~sig, then update prev_q <= sig.
REQ-014 en=0 SHALL hold prev_q, seen masks and state; a change across an en-low gap SHALL be detected at the next en=1 sample against the held prev_q.
REQ-015 seen_rise and seen_fall SHALL be sticky per bit; a bit is complete when both are set.
REQ-016 newly = complete_next & ~complete_q; valid SHALL be registered, equal newly exactly one cycle after the detecting sample, and 0 otherwise.
REQ-017 Each bit's valid SHALL pulse at most once per clear epoch.
REQ-018 A bit whose rise and fall occur in different samples SHALL complete on the later one; multiple bits completing in one sample SHALL all pulse in the same cycle.
REQ-019 covered_cnt SHALL increase by popcount(newly) in the same cycle valid asserts; it is never decremented except by clear and never exceeds WIDTH.
REQ-020 When covered_cnt reaches WIDTH, SHALL enter DONE with all_covered=1; DONE SHALL ignore en and emit no valid.
REQ-021 clr=1 SHALL, next cycle, zero seen masks, valid and covered_cnt, deassert all_covered, and go to ARM; the sig sample of that cycle is discarded.
REQ-022 clr and en in the same cycle: clr SHALL win; the sample SHALL not be captured.
REQ-023 valid pulses in flight SHALL not be suppressed by a clr in the following cycle.

Reset
REQ-024 reset=0 at a gbl_clk edge SHALL force state ARM, prev_q=0, seen masks=0, valid=0, covered_cnt=0, all_covered=0.
REQ-025 reset SHALL take priority over clr and en; deassertion mid-activity SHALL restart from ARM with no spurious valid.

Structure
REQ-026 Shared package toggle_cover_pkg SHALL hold the state enum (ARM/RUN/DONE) and the COVER_TOTAL constant.
REQ-027 SHALL instantiate one sub-module, toggle_popcount (WIDTH in, CNT_W out, combinational), for the counter increment.

Verification (WIDTH=4)
REQ-028 Reset then en=1 with sig=0000, 1111, 0000 -> valid=0000, 0000, then 1111 one cycle after the third sample; covered_cnt=4; all_covered=1.
REQ-029 sig=0000, 0001, en=0 for 5 cycles with sig=0000, en=1 -> bit0 pulses once after the re-enabled sample; covered_cnt=1.
REQ-030 After bit0 is complete, toggle bit0 ten more times -> no further valid[0]; covered_cnt stays 1.
REQ-031 clr and en together with sig changing -> sample ignored; state=ARM; covered_cnt=0; next two en samples 0010, 0000 -> no pulse until bit1 also rises.
REQ-032 reset=0 in the cycle after all bits complete -> valid=0000, covered_cnt=0, all_covered=0 next cycle; DONE sig activity gives no pulse beforehand.
